// File: rtl/os_ctrl_pkg.sv
// Shared definitions for the instruction-source controller: FSM states,
// default context-switch opcodes and the fixed source indices.
package os_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BIOS,
    ST_OS,
    ST_PROC,
    ST_FLUSH
  } state_e;

  localparam logic [5:0] OPC_BOOT   = 6'b100111;
  localparam logic [5:0] OPC_SWITCH = 6'b101000;
  localparam logic [5:0] OPC_RETURN = 6'b101001;

  localparam int unsigned SRC_BIOS = 0;
  localparam int unsigned SRC_OS   = 1;

endpackage

// File: rtl/quantum_timer.sv
// Loadable down-counter for process time slices. expire_o is high while the
// count sits at zero; the count holds at zero until reloaded.
module quantum_timer #(
  parameter int unsigned QUANTUM = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

  logic [CW-1:0] cnt_q;

  // Reload on slice start, count down on enabled cycles, saturate at zero.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= CW'(QUANTUM - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/instruction_source_controller.sv
// Selects which instruction memory (BIOS, OS or a user process) feeds fetch,
// switching on opcodes decoded from the selected stream and inserting a NOP
// flush window on every switch.
// Optional feature: define PREEMPT_EN to add time-slice preemption of user
// processes back to the OS (quantum_timer instance + preempt_pulse).
module instruction_source_controller
  import os_ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_WIDTH = 6,
  parameter int unsigned NUM_SOURCES  = 4,
  parameter logic [OPCODE_WIDTH-1:0] BOOT_OPCODE   = OPCODE_WIDTH'(OPC_BOOT),
  parameter logic [OPCODE_WIDTH-1:0] SWITCH_OPCODE = OPCODE_WIDTH'(OPC_SWITCH),
  parameter logic [OPCODE_WIDTH-1:0] RETURN_OPCODE = OPCODE_WIDTH'(OPC_RETURN),
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned QUANTUM      = 1024,
  localparam int unsigned SEL_WIDTH   = $clog2(NUM_SOURCES)
) (
  input  logic                    CLOCK,
  input  logic                    RESET,
  input  logic [OPCODE_WIDTH-1:0] BIOS_INSTRUCTION_OPCODE,
  input  logic [SEL_WIDTH-1:0]    INSTRUCTION_TARGET,
  input  logic                    STALL,
  output logic [SEL_WIDTH-1:0]    instruction_selection,
  output logic                    insert_nop,
  output logic                    os_mode,
  output logic                    bad_target,
  output logic                    preempt_pulse
);

  localparam int unsigned FCW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FCW-1:0]       FLUSH_LOAD = FCW'(FLUSH_CYCLES - 1);
  localparam logic [SEL_WIDTH-1:0] SEL_OS     = SEL_WIDTH'(SRC_OS);
  localparam logic [SEL_WIDTH-1:0] SEL_BIOS   = SEL_WIDTH'(SRC_BIOS);

  if (NUM_SOURCES < 3 || FLUSH_CYCLES < 1 || QUANTUM < 1) begin : g_param_check
    $error("instruction_source_controller: illegal parameter value");
  end

  state_e               state_q, state_d;
  logic [SEL_WIDTH-1:0] current_q, current_d;
  logic [SEL_WIDTH-1:0] pending;
  logic [FCW-1:0]       flush_cnt_q, flush_cnt_d;
  logic                 go_flush;
  logic                 bad_q, bad_d;
  logic                 target_ok;

  assign target_ok = (32'(INSTRUCTION_TARGET) >= 2) &&
                     (32'(INSTRUCTION_TARGET) < NUM_SOURCES);

`ifdef PREEMPT_EN
  logic qt_load, qt_en, qt_expire;
  logic preempt_q, preempt_d;

  // Every flush exit reloads the slice; only ST_PROC cycles consume it.
  assign qt_load = (state_q == ST_FLUSH) && (state_d != ST_FLUSH);
  assign qt_en   = (state_q == ST_PROC) && !STALL;

  quantum_timer #(
    .QUANTUM (QUANTUM)
  ) u_qtimer (
    .clk_i    (CLOCK),
    .rst_i    (RESET),
    .load_i   (qt_load),
    .en_i     (qt_en),
    .expire_o (qt_expire)
  );

  // Registered preemption pulse.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      preempt_q <= 1'b0;
    end else begin
      preempt_q <= preempt_d;
    end
  end

  assign preempt_pulse = preempt_q;
`else
  assign preempt_pulse = 1'b0;
`endif

  // State and context registers.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q     <= ST_BIOS;
      current_q   <= SEL_BIOS;
      flush_cnt_q <= '0;
      bad_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      current_q   <= current_d;
      flush_cnt_q <= flush_cnt_d;
      bad_q       <= bad_d;
    end
  end

  // Next-state decode: opcodes only act on unstalled, non-flush cycles.
  always_comb begin
    state_d     = state_q;
    current_d   = current_q;
    flush_cnt_d = flush_cnt_q;
    pending     = current_q;
    go_flush    = 1'b0;
    bad_d       = 1'b0;
`ifdef PREEMPT_EN
    preempt_d   = 1'b0;
`endif
    unique case (state_q)
      ST_BIOS: begin
        if (!STALL && BIOS_INSTRUCTION_OPCODE == BOOT_OPCODE) begin
          pending  = SEL_OS;
          go_flush = 1'b1;
        end
      end
      ST_OS: begin
        if (!STALL && BIOS_INSTRUCTION_OPCODE == SWITCH_OPCODE) begin
          if (target_ok) begin
            pending  = INSTRUCTION_TARGET;
            go_flush = 1'b1;
          end else begin
            bad_d = 1'b1;
          end
        end
      end
      ST_PROC: begin
        if (!STALL) begin
          if (BIOS_INSTRUCTION_OPCODE == RETURN_OPCODE) begin
            pending  = SEL_OS;
            go_flush = 1'b1;
          end
`ifdef PREEMPT_EN
          // A return on the expiry cycle wins, so no preempt pulse then.
          else if (qt_expire) begin
            pending   = SEL_OS;
            go_flush  = 1'b1;
            preempt_d = 1'b1;
          end
`endif
        end
      end
      ST_FLUSH: begin
        if (!STALL) begin
          if (flush_cnt_q == '0) begin
            state_d = (current_q == SEL_OS) ? ST_OS : ST_PROC;
          end else begin
            flush_cnt_d = flush_cnt_q - 1'b1;
          end
        end
      end
    endcase
    // The new source is committed at flush entry so selection moves with the NOPs.
    if (go_flush) begin
      state_d     = ST_FLUSH;
      current_d   = pending;
      flush_cnt_d = FLUSH_LOAD;
    end
  end

  // Outputs derived from registers only.
  always_comb begin
    instruction_selection = current_q;
    insert_nop            = (state_q == ST_FLUSH);
    os_mode               = (current_q == SEL_OS) && (state_q != ST_BIOS);
    bad_target            = bad_q;
  end

endmodule

// File: tb/tb_instruction_source_controller.sv
// Self-checking bench for instruction_source_controller: directed scenarios
// followed by randomized opcodes/stalls/resets against a behavioural model.
module tb_instruction_source_controller;

  localparam int unsigned NS = 5;
  localparam int unsigned SW = 3;
  localparam int unsigned FC = 2;
  localparam int unsigned QN = 8;
  localparam logic [5:0] OP_BOOT   = 6'b100111;
  localparam logic [5:0] OP_SWITCH = 6'b101000;
  localparam logic [5:0] OP_RETURN = 6'b101001;

  logic          CLOCK = 1'b0;
  logic          RESET;
  logic [5:0]    op;
  logic [SW-1:0] tgt;
  logic          stall;
  logic [SW-1:0] sel;
  logic          nop, osm, badt, pre;

  int unsigned total = 0;
  int unsigned bad   = 0;

  // Behavioural model: which source is live, how many NOP cycles remain,
  // how many slice cycles remain, and the pulses due this cycle.
  bit          m_bios;
  int unsigned m_sel;
  int unsigned m_nop;
  int unsigned m_q;
  bit          m_bad, m_pre;

  always #5 CLOCK = ~CLOCK;

  instruction_source_controller #(
    .OPCODE_WIDTH (6),
    .NUM_SOURCES  (NS),
    .FLUSH_CYCLES (FC),
    .QUANTUM      (QN)
  ) dut (
    .CLOCK                   (CLOCK),
    .RESET                   (RESET),
    .BIOS_INSTRUCTION_OPCODE (op),
    .INSTRUCTION_TARGET      (tgt),
    .STALL                   (stall),
    .instruction_selection   (sel),
    .insert_nop              (nop),
    .os_mode                 (osm),
    .bad_target              (badt),
    .preempt_pulse           (pre)
  );

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_bios = 1'b1;
    m_sel  = 0;
    m_nop  = 0;
    m_q    = 0;
    m_bad  = 1'b0;
    m_pre  = 1'b0;
  endfunction

  function automatic void model_step(input logic [5:0] o, input int unsigned t, input bit s);
    m_bad = 1'b0;
    m_pre = 1'b0;
    if (m_nop > 0) begin
      if (!s) begin
        m_nop--;
        if (m_nop == 0 && m_sel >= 2) m_q = QN;
      end
    end else if (!s) begin
      if (m_bios) begin
        if (o == OP_BOOT) begin
          m_bios = 1'b0;
          m_sel  = 1;
          m_nop  = FC;
        end
      end else if (m_sel == 1) begin
        if (o == OP_SWITCH) begin
          if (t >= 2 && t < NS) begin
            m_sel = t;
            m_nop = FC;
          end else begin
            m_bad = 1'b1;
          end
        end
      end else begin
        if (o == OP_RETURN) begin
          m_sel = 1;
          m_nop = FC;
        end else begin
`ifdef PREEMPT_EN
          m_q--;
          if (m_q == 0) begin
            m_sel = 1;
            m_nop = FC;
            m_pre = 1'b1;
          end
`endif
        end
      end
    end
  endfunction

  task automatic check_all();
    chk("sel",        sel,  m_sel);
    chk("insert_nop", nop,  (m_nop > 0));
    chk("os_mode",    osm,  (!m_bios && m_sel == 1));
    chk("bad_target", badt, m_bad);
    chk("preempt",    pre,  m_pre);
  endtask

  task automatic cycle(input logic [5:0] o, input logic [SW-1:0] t, input bit s);
    op    = o;
    tgt   = t;
    stall = s;
    @(posedge CLOCK);
    model_step(o, t, s);
    #1;
    check_all();
  endtask

  // Pulse reset between clock edges; outputs must clear without an edge.
  task automatic async_reset(input string tag);
    #3 RESET = 1'b1;
    #1;
    model_reset();
    check_all();
    chk({tag, "_sel"}, sel, 0);
    chk({tag, "_nop"}, nop, 0);
    #2 RESET = 1'b0;
  endtask

  initial begin
    int unsigned nop_len;
    logic [5:0]  ro;
    int unsigned r;

    RESET = 1'b1;
    op    = '0;
    tgt   = '0;
    stall = 1'b0;
    model_reset();
    #12;
    check_all();
    RESET = 1'b0;

    // Boot at cycle 5.
    for (int i = 1; i <= 4; i++) cycle(6'($urandom_range(0, 38)), 3'($urandom), 1'b0);
    cycle(OP_BOOT, '0, 1'b0);
    chk("boot_sel", sel, 1);
    chk("boot_nop", nop, 1);
    cycle('0, '0, 1'b0);
    chk("boot_nop2", nop, 1);
    cycle('0, '0, 1'b0);
    chk("boot_done_nop", nop, 0);
    chk("boot_os_mode", osm, 1);

    // OS -> process 3 -> OS.
    cycle(OP_SWITCH, 3'd3, 1'b0);
    chk("sw3_sel", sel, 3);
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);
    chk("sw3_run_nop", nop, 0);
    cycle(OP_RETURN, '0, 1'b0);
    chk("ret_sel", sel, 1);
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);

    // Illegal targets.
    for (int i = 0; i < 5; i++) begin
      logic [SW-1:0] bt;
      case (i)
        0: bt = 3'd0;
        1: bt = 3'd1;
        2: bt = 3'd5;
        3: bt = 3'd6;
        default: bt = 3'd7;
      endcase
      cycle(OP_SWITCH, bt, 1'b0);
      chk("bad_pulse", badt, 1);
      chk("bad_sel", sel, 1);
      cycle('0, '0, 1'b0);
      chk("bad_clear", badt, 0);
    end

    // Switch to process 2 with a 3-cycle stall inside the flush.
    cycle(OP_SWITCH, 3'd2, 1'b0);
    nop_len = (nop == 1'b1) ? 1 : 0;
    for (int i = 0; i < 20 && nop; i++) begin
      cycle('0, '0, (i < 3));
      if (nop) nop_len++;
    end
    chk("stall_nop_len", nop_len, 5);

    // Return coincident with the 8th slice cycle: plain return.
    for (int i = 0; i < 7; i++) cycle(6'($urandom_range(0, 38)), '0, 1'b0);
    cycle(OP_RETURN, '0, 1'b0);
    chk("ret_coinc_pre", pre, 0);
    chk("ret_coinc_sel", sel, 1);
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);

    // Process 4 runs a full slice.
    cycle(OP_SWITCH, 3'd4, 1'b0);
    cycle('0, '0, 1'b0);
    cycle('0, '0, 1'b0);
    for (int i = 0; i < 8; i++) cycle('0, '0, 1'b0);
`ifdef PREEMPT_EN
    chk("preempt_pulse", pre, 1);
    chk("preempt_sel", sel, 1);
`else
    chk("no_preempt_pulse", pre, 0);
    chk("no_preempt_sel", sel, 4);
    cycle(OP_RETURN, '0, 1'b0);
`endif
    cycle('0, '0, 1'b0);
    chk("preempt_clear", pre, 0);
    cycle('0, '0, 1'b0);

    // Reset mid-flush toward process 2, then BIOS ignores stalled boot and return.
    cycle(OP_SWITCH, 3'd2, 1'b0);
    async_reset("rst_flush");
    cycle(OP_BOOT, '0, 1'b1);
    cycle(OP_BOOT, '0, 1'b1);
    chk("stalled_boot_sel", sel, 0);
    cycle(OP_RETURN, '0, 1'b0);
    chk("bios_ret_sel", sel, 0);
    chk("bios_ret_nop", nop, 0);

    // Randomized traffic.
    for (int n = 0; n < 800; n++) begin
      r = $urandom_range(0, 9);
      if (r < 3)      ro = OP_BOOT;
      else if (r < 6) ro = OP_SWITCH;
      else if (r < 8) ro = OP_RETURN;
      else            ro = 6'($urandom);
      cycle(ro, 3'($urandom), ($urandom_range(0, 4) == 0));
      if ($urandom_range(0, 199) == 0) async_reset("rnd_rst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
